// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: FWFT valid/ready output,
// fill level, and sticky overflow / frame-error flags.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rx_err,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic              frame_err,
    input  logic              clr_flags
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              ferr_q, ferr_d;

    logic good, push, pop, drop;

    assign m_valid = (count_q != '0);
    assign full    = (count_q == (ADDR_W+1)'(DEPTH));
    assign count   = count_q;
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;

    // Gated so the not-reset storage never leaks X onto m_data when empty.
    assign m_data = m_valid ? mem_q[rd_ptr_q] : '0;

    assign good = rx_done & ~rx_err;
    assign pop  = m_valid & m_ready;
    assign push = good & (~full | pop);
    assign drop = good & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d  = (ovf_q & ~clr_flags) | drop;
        ferr_d = (ferr_q & ~clr_flags) | (rx_done & rx_err);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

endmodule
